// File: rtl/pipe_pkg.sv
// Shared definitions for the N:1 skid-buffered mux: FSM state encodings and
// a select-width helper that stays at least one bit wide.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Purely combinational N:1 operand select; out-of-range selects yield DEFAULT
// and raise err so the consumer can tell a real operand from the filler value.
module mux_nto1_comb
    import pipe_pkg::*;
#(
    parameter int              WIDTH   = 32,
    parameter int              NUM_IN  = 4,
    parameter logic [WIDTH-1:0] DEFAULT = '0,
    localparam int             SEL_W   = sel_w(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    always_comb begin
        data = DEFAULT;
        err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                data = in_data[i*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_skid.sv
// N:1 operand mux feeding a 2-entry skid buffer (head + skid registers) with a
// valid/ready handshake on both sides and a synchronous flush.
module mux_nto1_skid
    import pipe_pkg::*;
#(
    parameter int              WIDTH   = 32,
    parameter int              NUM_IN  = 4,
    parameter logic [WIDTH-1:0] DEFAULT = '0,
    localparam int             SEL_W   = sel_w(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    state_e           state_q;
    logic [WIDTH:0]   main_q;
    logic [WIDTH:0]   skid_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [WIDTH:0]   entry;
    logic             accept;
    logic             pop;

    mux_nto1_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .DEFAULT(DEFAULT)
    ) u_sel (
        .in_data(in_data),
        .sel    (in_sel),
        .data   (sel_data),
        .err    (sel_err)
    );

    assign entry  = {sel_err, sel_data};
    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // Head register always holds the oldest entry; skid only fills when the
    // head is stalled, so in_ready can be a pure register (state != FULL).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q      <= entry;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_q <= entry;
                    end else if (accept) begin
                        skid_q     <= entry;
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_q     <= skid_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q[WIDTH-1:0];
    assign out_err   = main_q[WIDTH];

endmodule
